spi_shifter: RTL and testbench

SPI_SHIFTER -- requirements
Module: spi_shifter

---
 rtl/spi_shifter_pkg.sv | 22 ++
 rtl/spi_bit_counter.sv | 31 +++
 rtl/spi_shifter.sv | 102 ++++++++++
 tb/tb_spi_shifter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_shifter_pkg.sv
// Shared definitions for the SPI shifter slice: default word length,
// shift-order encodings, controller states and the counter-width helper.
package spi_shifter_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic {
      MSB_FIRST = 1'b0,
      LSB_FIRST = 1'b1
   } mode_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   // Bits needed to hold a count of 0..width inclusive.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for the SPI shifter: clears on load, advances once per shift
// and flags the shift that completes the word.
module spi_bit_counter
   import spi_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

   // Terminal count: this shift brings the count to WIDTH.
   assign last = inc && (cnt == TERM);

   // Count register; the caller only asserts inc while a word is in flight,
   // so the count parks at WIDTH and never wraps.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/spi_shifter.sv
// SPI shift register: parallel load, serial shift in either bit order,
// parallel unload, with busy/done handshaking around each word.
module spi_shifter
   import spi_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   input  logic             Ld,
   input  logic             lsb_first,
   input  logic             en,
   input  logic             in,
   input  logic             un_ld,
   output logic             out,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_shifted;
   mode_e            mode;
   state_e           state, state_n;
   logic             done_n;
   logic             shift;
   logic             last;

   assign busy  = (state == S_BUSY);
   assign shift = en && busy && !Ld;

   // Serial output and next shift value, both steered by the latched mode.
   always_comb begin
      shreg_shifted = {shreg[WIDTH-2:0], in};
      out           = shreg[WIDTH-1];
      if (mode == LSB_FIRST) begin
         shreg_shifted = {in, shreg[WIDTH-1:1]};
         out           = shreg[0];
      end
   end

   spi_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (Ld),
      .inc  (shift),
      .cnt  (bit_cnt),
      .last (last)
   );

   // Datapath: shift register, latched mode and parallel result.
   // The final shift wins over un_ld so data_out captures the completed word;
   // otherwise un_ld captures the current (pre-load / pre-shift) contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         mode     <= MSB_FIRST;
         data_out <= '0;
      end else begin
         if (Ld) begin
            shreg <= data;
            mode  <= mode_e'(lsb_first);
         end else if (shift) begin
            shreg <= shreg_shifted;
         end
         if (last)
            data_out <= shreg_shifted;
         else if (un_ld)
            data_out <= shreg;
      end
   end

   // Controller state register and registered done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= done_n;
      end
   end

   // Next state: a load (re)starts a word, the last shift ends it.
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      if (Ld) begin
         state_n = S_BUSY;
      end else if (last) begin
         state_n = S_IDLE;
         done_n  = 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_shifter.sv
// Testbench for spi_shifter: directed scenarios with literal expectations,
// a loopback pair, a 16-bit instance, and randomized traffic checked against
// a bit-queue model of the word in flight.
module tb_spi_shifter;

   localparam int W = 8;

   int vectors = 0;
   int errors  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main 8-bit DUT ----------------
   logic         rst = 1'b1, ld = 1'b0, lsb = 1'b0, en = 1'b0, sin = 1'b0, un_ld = 1'b0;
   logic [W-1:0] data = '0;
   logic         out, busy, done;
   logic [W-1:0] data_out;
   logic [3:0]   bit_cnt;

   spi_shifter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .data(data), .Ld(ld), .lsb_first(lsb), .en(en),
      .in(sin), .un_ld(un_ld), .out(out), .data_out(data_out),
      .bit_cnt(bit_cnt), .busy(busy), .done(done)
   );

   // ---------------- loopback pair ----------------
   logic         lb_rst = 1'b1, lb_ld = 1'b0, lb_en = 1'b0;
   logic         a_out, b_out, a_busy, b_busy, a_done, b_done;
   logic [W-1:0] a_dout, b_dout;
   logic [3:0]   a_cnt, b_cnt;

   spi_shifter #(.WIDTH(W)) lb_a (
      .clk(clk), .rst(lb_rst), .data(8'h8E), .Ld(lb_ld), .lsb_first(1'b0), .en(lb_en),
      .in(b_out), .un_ld(1'b0), .out(a_out), .data_out(a_dout),
      .bit_cnt(a_cnt), .busy(a_busy), .done(a_done)
   );
   spi_shifter #(.WIDTH(W)) lb_b (
      .clk(clk), .rst(lb_rst), .data(8'hFF), .Ld(lb_ld), .lsb_first(1'b0), .en(lb_en),
      .in(a_out), .un_ld(1'b0), .out(b_out), .data_out(b_dout),
      .bit_cnt(b_cnt), .busy(b_busy), .done(b_done)
   );

   // ---------------- 16-bit instance ----------------
   logic        w_rst = 1'b1, w_ld = 1'b0, w_en = 1'b0, w_in = 1'b0;
   logic        w_out, w_busy, w_done;
   logic [15:0] w_dout;
   logic [4:0]  w_cnt;

   spi_shifter #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(w_rst), .data(16'hA5C3), .Ld(w_ld), .lsb_first(1'b0), .en(w_en),
      .in(w_in), .un_ld(1'b0), .out(w_out), .data_out(w_dout),
      .bit_cnt(w_cnt), .busy(w_busy), .done(w_done)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model of the main DUT ----------------
   // mq holds the register contents in transmit order: mq[0] is the bit
   // currently on out, later entries follow; received bits join at the back.
   bit           mq[$];
   bit           m_mode = 1'b0;
   bit           m_busy = 1'b0, m_done = 1'b0;
   int           m_cnt  = 0;
   logic [W-1:0] m_dout = '0;
   bit           chk_en = 1'b0;

   initial for (int i = 0; i < W; i++) mq.push_back(1'b0);

   function automatic logic [W-1:0] q2w();
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) begin
         if (m_mode) w[i] = mq[i];
         else        w[W-1-i] = mq[i];
      end
      return w;
   endfunction

   always @(posedge clk) begin
      logic [W-1:0] pre;
      pre = q2w();
      if (rst) begin
         mq.delete();
         for (int i = 0; i < W; i++) mq.push_back(1'b0);
         m_mode = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_dout = '0;
      end else begin
         m_done = 1'b0;
         if (ld) begin
            if (un_ld) m_dout = pre;
            m_mode = lsb;
            mq.delete();
            for (int i = 0; i < W; i++) mq.push_back(lsb ? data[i] : data[W-1-i]);
            m_cnt  = 0;
            m_busy = 1'b1;
         end else if (en && m_busy) begin
            void'(mq.pop_front());
            mq.push_back(sin);
            m_cnt++;
            if (m_cnt == W) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_dout = q2w();
            end else if (un_ld) begin
               m_dout = pre;
            end
         end else if (un_ld) begin
            m_dout = pre;
         end
      end
   end

   // Compare process: every cycle once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out",      {31'd0, out},     {31'd0, mq[0]});
         chk("m_busy",     {31'd0, busy},    {31'd0, m_busy});
         chk("m_done",     {31'd0, done},    {31'd0, m_done});
         chk("m_bit_cnt",  {28'd0, bit_cnt}, m_cnt);
         chk("m_data_out", {24'd0, data_out}, {24'd0, m_dout});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  seq;
   logic [15:0] expw;
   int          n;

   initial begin
      // reset
      step(); step();
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_out", {31'd0, out}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_cnt", {28'd0, bit_cnt}, 0);
      chk("rst_dout", {24'd0, data_out}, 0);

      // MSB-first, in=0
      data = 8'h8E; lsb = 1'b0; ld = 1'b1; step(); ld = 1'b0;
      chk("msb_cnt0", {28'd0, bit_cnt}, 0);
      seq = 8'b1000_1110;
      en = 1'b1; sin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("msb_out", {31'd0, out}, {31'd0, seq[7-i]});
         chk("msb_nodone", {31'd0, done}, 0);
         step();
      end
      en = 1'b0;
      chk("msb_done", {31'd0, done}, 1);
      chk("msb_busy", {31'd0, busy}, 0);
      chk("msb_dout", {24'd0, data_out}, 8'h00);
      chk("msb_cnt8", {28'd0, bit_cnt}, 8);
      step();
      chk("msb_done_pulse", {31'd0, done}, 0);

      // LSB-first, in=1: out 0,1,1,1,0,0,0,1
      data = 8'h8E; lsb = 1'b1; ld = 1'b1; step(); ld = 1'b0;
      seq = 8'b0111_0001;
      en = 1'b1; sin = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("lsb_out", {31'd0, out}, {31'd0, seq[7-i]});
         step();
      end
      en = 1'b0;
      chk("lsb_done", {31'd0, done}, 1);
      chk("lsb_dout", {24'd0, data_out}, 8'hFF);

      // Ld and en together: load wins; en after done is ignored
      data = 8'h3C; lsb = 1'b0; ld = 1'b1; en = 1'b1; sin = 1'b1; step();
      ld = 1'b0; en = 1'b0;
      chk("prio_cnt", {28'd0, bit_cnt}, 0);
      chk("prio_out", {31'd0, out}, 0);
      chk("prio_busy", {31'd0, busy}, 1);
      un_ld = 1'b1; step(); un_ld = 1'b0;
      chk("prio_shreg", {24'd0, data_out}, 8'h3C);
      en = 1'b1;
      repeat (8) step();
      chk("prio_done", {31'd0, done}, 1);
      repeat (3) step();
      chk("prio_cnt_hold", {28'd0, bit_cnt}, 8);
      chk("prio_dout_hold", {24'd0, data_out}, 8'hFF);
      chk("prio_idle", {31'd0, busy}, 0);
      en = 1'b0;

      // reset mid-word
      data = 8'hA5; ld = 1'b1; step(); ld = 1'b0;
      en = 1'b1; repeat (3) step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("rmid_out", {31'd0, out}, 0);
      chk("rmid_cnt", {28'd0, bit_cnt}, 0);
      chk("rmid_busy", {31'd0, busy}, 0);
      chk("rmid_dout", {24'd0, data_out}, 0);
      for (int i = 0; i < 10; i++) begin
         chk("rmid_nodone", {31'd0, done}, 0);
         step();
      end
      en = 1'b0;

      // loopback pair
      lb_rst = 1'b0; lb_ld = 1'b1; step(); lb_ld = 1'b0;
      lb_en = 1'b1;
      repeat (7) step();
      chk("lb_early_a", {31'd0, a_done}, 0);
      chk("lb_early_b", {31'd0, b_done}, 0);
      step();
      lb_en = 1'b0;
      chk("lb_done_a", {31'd0, a_done}, 1);
      chk("lb_done_b", {31'd0, b_done}, 1);
      chk("lb_dout_a", {24'd0, a_dout}, 8'hFF);
      chk("lb_dout_b", {24'd0, b_dout}, 8'h8E);

      // 16-bit word
      w_rst = 1'b0; w_ld = 1'b1; step(); w_ld = 1'b0;
      chk("w16_out0", {31'd0, w_out}, 1);
      w_en = 1'b1; n = 0; expw = '0;
      while (!w_done && n < 40) begin
         w_in = 1'($urandom);
         expw = {expw[14:0], w_in};
         step();
         n++;
      end
      w_en = 1'b0;
      chk("w16_latency", n, 16);
      chk("w16_cnt", {27'd0, w_cnt}, 16);
      chk("w16_dout", {16'd0, w_dout}, {16'd0, expw});

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(99) == 0);
         ld    = ($urandom_range(11) == 0);
         en    = ($urandom_range(3) != 0);
         un_ld = ($urandom_range(7) == 0);
         sin   = 1'($urandom);
         lsb   = 1'($urandom);
         data  = 8'($urandom);
         step();
      end
      rst = 1'b0; ld = 1'b0; en = 1'b0; un_ld = 1'b0;
      @(negedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
